// File: rtl/mini_micro_pkg.sv
// Shared types and constants for the mini micro fetch path.
// Includes a helper that sizes index counters so that one-read words stay legal.
package mini_micro_pkg;

  typedef enum logic [1:0] {
    S_ISSUE,
    S_DRAIN,
    S_VALID
  } fetch_state_t;

  localparam int INSTR_WORD_SIZE  = 32;
  localparam int INSTR_MEM_DATA_W = 8;
  localparam int INSTR_MEM_DEPTH  = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Capture pipe for the instruction memory: remembers which slice is in flight
// and shifts the returning read into its little-endian position of instr.
module fetch_byte_assembler
  import mini_micro_pkg::*;
#(
  parameter int MEM_DATA_W = INSTR_MEM_DATA_W,
  parameter int BYTES      = INSTR_WORD_SIZE / INSTR_MEM_DATA_W,
  parameter int IDX_W      = idx_width(BYTES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue,
  input  logic [IDX_W-1:0]              issue_idx,
  input  logic [MEM_DATA_W-1:0]         mem_rdata,
  output logic [BYTES*MEM_DATA_W-1:0]   instr
);

  logic                        cap_vld;
  logic [IDX_W-1:0]            cap_idx;
  logic [BYTES*MEM_DATA_W-1:0] instr_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of process evaluation order.
  // NOTE: instr_q is reset even though it is plain datapath, because it is
  // a visible output whose reset value of zero is part of the interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld <= 1'b0;
      cap_idx <= '0;
      instr_q <= '0;
    end else begin
      // A flush kills the read issued this cycle; its data returns next cycle.
      cap_vld <= issue && !flush;
      cap_idx <= issue_idx;
      if (cap_vld) begin
        instr_q[int'(cap_idx)*MEM_DATA_W +: MEM_DATA_W] <= mem_rdata;
      end
    end
  end

  assign instr = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: walks the PC through byte-wide memory, assembles one
// instruction per BYTES reads and hands it over on a valid/ready handshake.
module instruction_fetch_unit
  import mini_micro_pkg::*;
#(
  parameter int WORD_SIZE  = INSTR_WORD_SIZE,
  parameter int MEM_DATA_W = INSTR_MEM_DATA_W,
  parameter int MEM_DEPTH  = INSTR_MEM_DEPTH,
  parameter int ADDR_W     = $clog2(MEM_DEPTH),
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_W-1:0]     branch_target,
  output logic [WORD_SIZE-1:0]  instr,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fetch_busy
);

  localparam int BYTES = WORD_SIZE / MEM_DATA_W;
  localparam int IDX_W = idx_width(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(MEM_DEPTH - BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES - 1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic [IDX_W-1:0]  idx;
  logic              armed;
  logic              issue, last_issue, accept;

  // Aligned words never straddle the end of memory, so only pc needs wrapping.
  assign mem_addr = pc + ADDR_W'(idx);
  assign pc_inc   = (pc == LAST_PC) ? '0 : pc + ADDR_W'(BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ISSUE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (branch_valid) begin
      state_nxt = S_ISSUE;
    end else begin
      case (state)
        S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = S_VALID;
        S_VALID: if (instr_ready) state_nxt = S_ISSUE;
        default: state_nxt = S_ISSUE;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    issue      = 1'b0;
    last_issue = 1'b0;
    accept     = 1'b0;
    fetch_busy = 1'b0;
    case (state)
      S_ISSUE: begin
        issue      = !stall;
        last_issue = !stall && (idx == LAST_IDX);
        fetch_busy = armed;
      end
      S_DRAIN: fetch_busy = armed;
      S_VALID: accept = instr_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= ADDR_W'(RESET_PC);
      idx         <= '0;
      instr_pc    <= ADDR_W'(RESET_PC);
      instr_valid <= 1'b0;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (branch_valid) begin
        pc          <= branch_target & ALIGN_MASK;
        idx         <= '0;
        instr_valid <= 1'b0;
      end else begin
        if (issue) idx <= last_issue ? '0 : idx + IDX_W'(1);
        if (state == S_DRAIN) begin
          instr_valid <= 1'b1;
          instr_pc    <= pc;
        end
        if (accept) begin
          instr_valid <= 1'b0;
          pc          <= pc_inc;
        end
      end
    end
  end

  fetch_byte_assembler #(
    .MEM_DATA_W (MEM_DATA_W),
    .BYTES      (BYTES),
    .IDX_W      (IDX_W)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_valid),
    .issue     (issue),
    .issue_idx (idx),
    .mem_rdata (mem_rdata),
    .instr     (instr)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch unit against a byte memory and
// a transaction-level model of PC sequencing and fetch latency.
module tb_instruction_fetch_unit;

  localparam int WORD_SIZE  = 32;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 64;
  localparam int ADDR_W     = 6;
  localparam int BYTES      = WORD_SIZE / MEM_DATA_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_W-1:0]     mem_addr;
  logic [MEM_DATA_W-1:0] mem_rdata;
  logic                  stall;
  logic                  branch_valid;
  logic [ADDR_W-1:0]     branch_target;
  logic [WORD_SIZE-1:0]  instr;
  logic [ADDR_W-1:0]     instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  fetch_busy;

  logic [MEM_DATA_W-1:0] mem [MEM_DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data appears one cycle after address.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  function automatic logic [31:0] word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  int n;
  int m_pc, m_r;
  bit m_v;

  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    instr_ready   = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'($urandom_range(1, 255));
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    #1;
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_instr", 64'(instr), 64'(0));
    check("rst_instr_pc", 64'(instr_pc), 64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_busy", 64'(fetch_busy), 64'(0));
    tick();
    tick();
    rst = 1'b1;

    // First fetch: valid in cycle BYTES+1 after release.
    check("c0_busy", 64'(fetch_busy), 64'(0));
    check("c0_addr", 64'(mem_addr), 64'(0));
    tick();
    check("c1_busy", 64'(fetch_busy), 64'(1));
    check("c1_addr", 64'(mem_addr), 64'(1));
    wait_valid(20, n);
    check("first_latency", 64'(n), 64'(4));
    check("first_instr", 64'(instr), 64'(32'h44332211));
    check("first_pc", 64'(instr_pc), 64'(0));
    tick();
    check("accept_valid", 64'(instr_valid), 64'(0));
    check("accept_addr", 64'(mem_addr), 64'(4));
    wait_valid(20, n);
    check("second_latency", 64'(n), 64'(5));
    check("second_pc", 64'(instr_pc), 64'(4));
    check("second_instr", 64'(instr), 64'(word(4)));

    // Backpressure: everything held while ready is low.
    instr_ready = 1'b0;
    check("valid_busy", 64'(fetch_busy), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold", 64'({instr_valid, instr_pc, instr, mem_addr}),
            64'({1'b1, 6'd4, word(4), 6'd4}));
    end
    instr_ready = 1'b1;
    tick();
    check("release_valid", 64'(instr_valid), 64'(0));
    check("release_addr", 64'(mem_addr), 64'(8));

    // Stall three cycles after the second byte issues.
    tick();
    tick();
    check("pre_stall_addr", 64'(mem_addr), 64'(10));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 64'(mem_addr), 64'(10));
    end
    stall = 1'b0;
    wait_valid(20, n);
    check("stall_latency", 64'(n), 64'(3));
    check("stall_instr", 64'(instr), 64'(word(8)));
    check("stall_pc", 64'(instr_pc), 64'(8));

    // Branch mid-fetch to an unaligned target.
    tick();
    check("q0_addr", 64'(mem_addr), 64'(12));
    tick();
    tick();
    check("q2_addr", 64'(mem_addr), 64'(14));
    branch_valid  = 1'b1;
    branch_target = 6'h12;
    tick();
    branch_valid = 1'b0;
    check("br_addr", 64'(mem_addr), 64'(6'h10));
    check("br_valid", 64'(instr_valid), 64'(0));
    wait_valid(20, n);
    check("br_latency", 64'(n), 64'(5));
    check("br_pc", 64'(instr_pc), 64'(6'h10));
    check("br_instr", 64'(instr), 64'(word(16)));

    // Branch coincident with acceptance, then PC wrap at the top of memory.
    branch_valid  = 1'b1;
    branch_target = 6'd60;
    tick();
    branch_valid = 1'b0;
    check("br_acc_valid", 64'(instr_valid), 64'(0));
    check("br_acc_addr", 64'(mem_addr), 64'(60));
    wait_valid(20, n);
    check("top_latency", 64'(n), 64'(5));
    check("top_pc", 64'(instr_pc), 64'(60));
    check("top_instr", 64'(instr), 64'(word(60)));
    tick();
    check("wrap_addr", 64'(mem_addr), 64'(0));
    wait_valid(20, n);
    check("wrap_pc", 64'(instr_pc), 64'(0));
    branch_valid  = 1'b1;
    branch_target = 6'h21;
    tick();
    branch_valid = 1'b0;
    check("br_not_inc_addr", 64'(mem_addr), 64'(6'h20));
    tick();
    tick();
    check("mid_issue_addr", 64'(mem_addr), 64'(6'h22));

    // Asynchronous reset mid-fetch.
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(instr_valid), 64'(0));
    check("arst_instr", 64'(instr), 64'(0));
    check("arst_addr", 64'(mem_addr), 64'(0));
    check("arst_pc", 64'(instr_pc), 64'(0));
    check("arst_busy", 64'(fetch_busy), 64'(0));
    tick();
    rst = 1'b1;
    wait_valid(20, n);
    check("post_rst_latency", 64'(n), 64'(5));
    check("post_rst_pc", 64'(instr_pc), 64'(0));
    check("post_rst_instr", 64'(instr), 64'(32'h44332211));

    // Randomized traffic against the transaction model.
    rst = 1'b0;
    tick();
    rst  = 1'b1;
    m_pc = 0;
    m_r  = BYTES;
    m_v  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_valid", 64'(instr_valid), 64'(m_v));
      if (m_v) begin
        check("rnd_pc", 64'(instr_pc), 64'(m_pc));
        check("rnd_instr", 64'(instr), 64'(word(m_pc)));
      end else if (m_r > 0) begin
        check("rnd_addr", 64'(mem_addr), 64'(m_pc + BYTES - m_r));
      end
      stall         = ($urandom_range(3) == 0);
      instr_ready   = ($urandom_range(4) < 3);
      branch_valid  = ($urandom_range(19) == 0);
      branch_target = ADDR_W'($urandom_range(MEM_DEPTH - 1));
      if (branch_valid) begin
        m_pc = int'(branch_target) & ~(BYTES - 1);
        m_r  = BYTES;
        m_v  = 1'b0;
      end else if (m_v) begin
        if (instr_ready) begin
          m_v  = 1'b0;
          m_r  = BYTES;
          m_pc = (m_pc + BYTES) % MEM_DEPTH;
        end
      end else if (m_r > 0) begin
        if (!stall) m_r--;
      end else begin
        m_v = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Parametrised fetch sequencer between the byte-wide instruction memory and the control unit.
- Generates byte addresses from an internal program counter and assembles MEM_DATA_W-wide reads, little-endian, into WORD_SIZE instructions.
- Presents each instruction to the control unit through a valid/ready handshake.
- Adds behaviour the current fetch path lacks: stall, branch redirect with flush, backpressure and PC wrap.

Parameters:
- WORD_SIZE, 32, instruction width in bits.
- MEM_DATA_W, 8, instruction memory data width; WORD_SIZE must be a multiple of it.
- MEM_DEPTH, 64, instruction memory depth in entries; must be a multiple of BYTES.
- ADDR_W, $clog2(MEM_DEPTH), address width.
- BYTES, WORD_SIZE/MEM_DATA_W, reads per instruction (derived, not overridable).
- RESET_PC, 0, PC after reset; must be BYTES-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rdata  in  MEM_DATA_W  memory read data, valid one cycle after its address.
- stall  in  1  freeze address issue.
- branch_valid  in  1  redirect request.
- branch_target  in  ADDR_W  redirect address.
- instr  out  WORD_SIZE  assembled instruction.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  consumer accepts.
- fetch_busy  out  1  high in S_ISSUE/S_DRAIN.

Behaviour:
- Reset state (rst=0, asynchronous):
  - pc=RESET_PC, idx=0, state=S_ISSUE.
  - mem_addr=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0, fetch_busy=0.
  - Capture-valid pipe cleared.
  - fetch_busy goes to 1 on the first clock after release.
- mem_addr = (pc+idx) mod MEM_DEPTH, driven from registers only (no combinational input path).
- S_ISSUE:
  - Each non-stalled cycle: issue address, set cap_vld<=1 and cap_idx<=idx, idx++.
  - After issuing idx=BYTES-1: idx<=0, go to S_DRAIN.
- Capture: any cycle with cap_vld=1 writes mem_rdata into instr bits [cap_idx*MEM_DATA_W +: MEM_DATA_W].
- S_DRAIN: captures the last byte, then goes to S_VALID with instr_valid<=1 and instr_pc<=pc.
- S_VALID:
  - instr, instr_pc and instr_valid are held stable until instr_ready=1.
  - On acceptance: instr_valid<=0, pc<=(pc+BYTES) mod MEM_DEPTH, go to S_ISSUE.
- Latency: first address issued in cycle 0; instr_valid is high in cycle BYTES+1. Throughput is one instruction per BYTES+2 cycles with ready held high.
- stall:
  - Freezes idx and state in S_ISSUE; cap_vld<=0 during stall cycles.
  - The in-flight byte from the previous cycle is still captured.
  - No effect in S_DRAIN or S_VALID.
- branch_valid (highest priority, any state):
  - pc<=branch_target with the low $clog2(BYTES) bits cleared; idx<=0; cap_vld<=0; instr_valid<=0; state<=S_ISSUE.
  - The byte returning in the next cycle is discarded.
- Simultaneous events:
  - branch_valid with stall: branch wins.
  - branch_valid with instr_ready in S_VALID: the held instruction counts as consumed; pc takes the target, not pc+BYTES.
- Wrap: pc at MEM_DEPTH-BYTES advances to 0; an aligned word never straddles the wrap.
- Reset mid-fetch: partial instr is discarded; all outputs return to reset values immediately.

Decomposition:
- Shared package mini_micro_pkg:
  - fetch_state_t enum {S_ISSUE, S_DRAIN, S_VALID}.
  - Constants INSTR_WORD_SIZE=32, INSTR_MEM_DATA_W=8, INSTR_MEM_DEPTH=64.
- One sub-module: fetch_byte_assembler. It holds the cap_vld/cap_idx pipe and the instr shift-in register, with a flush input.

Test Plan:
- Memory bytes 0..3 = 11,22,33,44; release reset; ready=1 -> instr_valid in cycle 5 with instr=0x44332211, instr_pc=0; next word at pc=4 valid 6 cycles later.
- Hold instr_ready=0 for 10 cycles in S_VALID -> instr/instr_pc stable, mem_addr constant at pc; on ready=1, next issue address = pc+4.
- Assert stall for 3 cycles after the 2nd byte issued -> same instr value as unstalled; valid delayed by exactly 3 cycles.
- branch_valid with target=0x12 during idx=2 -> mem_addr=0x10 next cycle; byte from address 0x12 discarded; instr_pc=0x10 with bytes 0x10..0x13.
- Fetch from pc=60 accepted -> next mem_addr=0; branch_valid coincident with instr_ready -> pc=target, not 0.
- Drop rst mid-S_ISSUE -> instr_valid=0, instr=0, mem_addr=RESET_PC asynchronously; clean fetch from RESET_PC after release.
